vga_scan_gen: RTL and testbench
===============================

// Module: vga_scan_gen
// PURPOSE
//  Parametrised raster timing and character-cell address generator; next generation of the fixed 640x480 text timing.
//  Derives a pixel enable from clk, runs h/v counters with programmable totals, and outputs sync, blank, frame IRQ, and cell/glyph coordinates.
//  Sits between the system clock and the char buffer/font ROM/pixel mux of any text or bitmap display.
// PARAMETERS
//  PIX_DIV      2    clk cycles per pixel (>=1); pix_en pulses once every PIX_DIV clocks
//  H_ACTIVE     640  visible pixels per line
//  H_SYNC_START 652  hcount at which hsync asserts
//  H_SYNC_END   746  hcount at which hsync deasserts
//  H_TOTAL      794  pixels per line (hcount 0..H_TOTAL-1)
//  V_ACTIVE     480  visible lines
//  V_SYNC_START 492  vcount at which vsync asserts
//  V_SYNC_END   494  vcount at which vsync deasserts
//  V_TOTAL      528  lines per frame
//  H_SYNC_POL   0    hsync active level (0 = active low)
//  V_SYNC_POL   0    vsync active level
//  CELL_W       8    glyph width in pixels
//  CELL_H       12   glyph height in lines
//  COLS         80   cells per row (H_ACTIVE/CELL_W)
//  ADDR_W       12   cell_addr width
// PORTS
//  clk        in  1       system clock
//  rst_n      in  1       asynchronous active-low reset
//  pix_en     out 1       pixel enable, one clk wide
//  hsync      out 1       horizontal sync, polarity per H_SYNC_POL
//  vsync      out 1       vertical sync, polarity per V_SYNC_POL
//  blank      out 1       1 outside active area
//  hcount     out 11      current pixel column
//  vcount     out 11      current line
//  cell_addr  out ADDR_W  cell_row*COLS + cell_col of current pixel
//  glyph_x    out 4       hcount mod CELL_W
//  glyph_y    out 5       vcount mod CELL_H
//  irq_frame  out 1       frame interrupt, sticky
//  irq_clear  in  1       clears irq_frame
//  line_cmp   in  11      line-compare value (VGA_LINE_IRQ_EN only)
//  irq_line   out 1       line interrupt, sticky (VGA_LINE_IRQ_EN only)
// BEHAVIOUR
//  Reset: all counters 0; hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, blank=0, irq_*=0, pix_en=0, cell_addr/glyph_*=0.
//  Divider: counts 0..PIX_DIV-1; pix_en=1 in the cycle the count is PIX_DIV-1. With PIX_DIV=1, pix_en is constantly 1 after reset.
//  Counters advance only on pix_en. hcount wraps H_TOTAL-1->0; on that wrap vcount increments, wrapping V_TOTAL-1->0.
//  All outputs are registered and updated in the same clk edge as their counters; zero skew between hcount/vcount and sync/blank/cell/glyph outputs.
//  hsync active iff H_SYNC_START<=hcount<H_SYNC_END. vsync uses the same rule on vcount. blank = hcount>=H_ACTIVE | vcount>=V_ACTIVE.
//  glyph_x/glyph_y are wrap counters (no divide); cell_col steps when glyph_x wraps; cell_addr = line_base + cell_col.
//  line_base advances by COLS when glyph_y wraps at line end (adder, no multiplier). All cell state resets to 0 at hcount/vcount wrap.
//  Outside the active area, cell_addr and glyph_* hold their counted values; consumers must gate with blank.
//  irq_frame sets on the pix_en where hcount==H_TOTAL-1 && vcount==V_ACTIVE-1 (entry to vertical blank). It clears on irq_clear. Set wins over a same-cycle clear.
//  Async reset mid-frame restarts at pixel (0,0) of a new frame. Illegal parameter orderings (SYNC_END>TOTAL, etc.) fail elaboration via a generate-time check.
// CONFIGURATION
//  VGA_LINE_IRQ_EN defined: irq_line sets on the pix_en where hcount==H_TOTAL-1 and next vcount==line_cmp, and clears on irq_clear.
//   Set wins over a same-cycle clear. line_cmp>=V_TOTAL never fires.
//  VGA_LINE_IRQ_EN undefined: line_cmp is ignored and irq_line is tied 0.
// STRUCTURE
//  Package vga_pkg: timing localparams for 640x480@60 and 800x600@60, sync polarity constants, and the COORD_W=11 width constant.
//  Sub-module vga_axis_ctr: one counter with TOTAL, SYNC_START/END, ACTIVE and POL parameters; outputs count, sync, active and wrap.
//   Instantiated twice: h stepped by pix_en, v stepped by h wrap. The top level adds the divider, cell/glyph tracking and IRQs.
// TESTING
//  Small params (PIX_DIV=2, H 16/18/20/24, V 8/9/10/12, CELL 4x4, COLS 4):
//   pix_en every 2nd clk; hcount 23->0 with vcount+1; vcount 11->0 at the frame end.
//  Sync/blank: hsync low for hcount 18..19 only; vsync low for lines 9 only; blank=1 at hcount 16 and line 8.
//  Cell address: pixel (5,6) gives cell_addr 5 (row1*4+col1), glyph_x 1, glyph_y 2. Pixel (15,7) gives cell_addr 7, glyph (3,3).
//  irq_frame sets at pix_en (23,7). irq_clear pulsed on the same clk keeps it 1; a later irq_clear gives 0 on the next clk. No re-set before the next frame.
//  rst_n low at pixel (10,5) for 3 clks: all outputs hold reset values; after release the first pix_en shows (1,0)... counting from (0,0).
//  VGA_LINE_IRQ_EN, line_cmp=3: irq_line rises at the end of line 2. line_cmp=12: it never rises. Without the macro, irq_line stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, sync polarities and standard raster timings for vga_scan_gen
package vga_pkg;

  localparam int COORD_W = 11;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480@60 text timing (historical 794x528 totals)
  localparam int VGA640_H_ACTIVE     = 640;
  localparam int VGA640_H_SYNC_START = 652;
  localparam int VGA640_H_SYNC_END   = 746;
  localparam int VGA640_H_TOTAL      = 794;
  localparam int VGA640_V_ACTIVE     = 480;
  localparam int VGA640_V_SYNC_START = 492;
  localparam int VGA640_V_SYNC_END   = 494;
  localparam int VGA640_V_TOTAL      = 528;
  localparam bit VGA640_SYNC_POL     = SYNC_ACTIVE_LOW;

  // 800x600@60
  localparam int SVGA800_H_ACTIVE     = 800;
  localparam int SVGA800_H_SYNC_START = 840;
  localparam int SVGA800_H_SYNC_END   = 968;
  localparam int SVGA800_H_TOTAL      = 1056;
  localparam int SVGA800_V_ACTIVE     = 600;
  localparam int SVGA800_V_SYNC_START = 601;
  localparam int SVGA800_V_SYNC_END   = 605;
  localparam int SVGA800_V_TOTAL      = 628;
  localparam bit SVGA800_SYNC_POL     = SYNC_ACTIVE_HIGH;

  function automatic bit timing_ok(input int active, input int sync_start,
                                   input int sync_end, input int total);
    return (active > 0) && (active <= sync_start) && (sync_start <= sync_end) &&
           (sync_end <= total) && (total < (1 << COORD_W));
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// rtl/vga_axis_ctr.sv - one raster axis: wrapping counter with registered sync and active flags
module vga_axis_ctr
  import vga_pkg::*;
#(
  parameter int TOTAL      = VGA640_H_TOTAL,
  parameter int ACTIVE     = VGA640_H_ACTIVE,
  parameter int SYNC_START = VGA640_H_SYNC_START,
  parameter int SYNC_END   = VGA640_H_SYNC_END,
  parameter bit POL        = SYNC_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  output logic [COORD_W-1:0] count,
  output logic               sync,
  output logic               active,
  output logic               wrap
);

  if (!timing_ok(ACTIVE, SYNC_START, SYNC_END, TOTAL)) begin : g_bad_timing
    $error("vga_axis_ctr: illegal ACTIVE/SYNC_START/SYNC_END/TOTAL ordering");
  end

  localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACT_C  = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SS_C   = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SE_C   = COORD_W'(SYNC_END);

  logic [COORD_W-1:0] count_next;

  // Combinational so the next axis can step on the same edge as this one wraps.
  assign wrap = step && (count == LAST);

  always_comb begin
    count_next = count;
    if (step) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      sync   <= ~POL;
      active <= 1'b1;
    end else begin
      count  <= count_next;
      sync   <= ((count_next >= SS_C) && (count_next < SE_C)) ? POL : ~POL;
      active <= (count_next < ACT_C);
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - raster timing and character-cell address generator (optional line IRQ: VGA_LINE_IRQ_EN)
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV      = 2,
  parameter int H_ACTIVE     = VGA640_H_ACTIVE,
  parameter int H_SYNC_START = VGA640_H_SYNC_START,
  parameter int H_SYNC_END   = VGA640_H_SYNC_END,
  parameter int H_TOTAL      = VGA640_H_TOTAL,
  parameter int V_ACTIVE     = VGA640_V_ACTIVE,
  parameter int V_SYNC_START = VGA640_V_SYNC_START,
  parameter int V_SYNC_END   = VGA640_V_SYNC_END,
  parameter int V_TOTAL      = VGA640_V_TOTAL,
  parameter bit H_SYNC_POL   = VGA640_SYNC_POL,
  parameter bit V_SYNC_POL   = VGA640_SYNC_POL,
  parameter int CELL_W       = 8,
  parameter int CELL_H       = 12,
  parameter int COLS         = 80,
  parameter int ADDR_W       = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic [ADDR_W-1:0]  cell_addr,
  output logic [3:0]         glyph_x,
  output logic [4:0]         glyph_y,
  output logic               irq_frame,
  input  logic               irq_clear,
  input  logic [COORD_W-1:0] line_cmp,
  output logic               irq_line
);

  if (PIX_DIV < 1 || CELL_W < 1 || CELL_W > 16 || CELL_H < 1 || CELL_H > 32 ||
      COLS < 1 || ADDR_W < 1) begin : g_bad_params
    $error("vga_scan_gen: illegal PIX_DIV/CELL/COLS/ADDR_W parameters");
  end

  localparam int                 DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [3:0]         CW_LAST  = 4'(CELL_W - 1);
  localparam logic [4:0]         CH_LAST  = 5'(CELL_H - 1);
  localparam logic [ADDR_W-1:0]  COLS_A   = ADDR_W'(COLS);
  localparam logic [COORD_W-1:0] V_LAST_ACTIVE = COORD_W'(V_ACTIVE - 1);

  logic [DIV_W-1:0]  div_cnt, div_next;
  logic              tick;
  logic              h_active, v_active, h_wrap, v_wrap;
  logic [ADDR_W-1:0] cell_col, line_base, col_next, base_next;
  logic [3:0]        gx_next;
  logic [4:0]        gy_next;
  logic              frame_set;

  // tick marks the edge on which pix_en rises; every counter steps on that same edge.
  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    tick     = (div_next == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pix_en  <= tick;
    end
  end

  vga_axis_ctr #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_SYNC_START),
    .SYNC_END(H_SYNC_END), .POL(H_SYNC_POL)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(tick),
    .count(hcount), .sync(hsync), .active(h_active), .wrap(h_wrap)
  );

  vga_axis_ctr #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_SYNC_START),
    .SYNC_END(V_SYNC_END), .POL(V_SYNC_POL)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(h_wrap),
    .count(vcount), .sync(vsync), .active(v_active), .wrap(v_wrap)
  );

  assign blank = ~(h_active & v_active);

  // Cell position tracked with wrap counters and a running row base, avoiding divide/multiply.
  always_comb begin
    gx_next   = glyph_x;
    gy_next   = glyph_y;
    col_next  = cell_col;
    base_next = line_base;
    if (h_wrap) begin
      gx_next  = '0;
      col_next = '0;
      if (v_wrap) begin
        gy_next   = '0;
        base_next = '0;
      end else if (glyph_y == CH_LAST) begin
        gy_next   = '0;
        base_next = line_base + COLS_A;
      end else begin
        gy_next = glyph_y + 1'b1;
      end
    end else if (tick) begin
      if (glyph_x == CW_LAST) begin
        gx_next  = '0;
        col_next = cell_col + 1'b1;
      end else begin
        gx_next = glyph_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_x   <= '0;
      glyph_y   <= '0;
      cell_col  <= '0;
      line_base <= '0;
      cell_addr <= '0;
    end else begin
      glyph_x   <= gx_next;
      glyph_y   <= gy_next;
      cell_col  <= col_next;
      line_base <= base_next;
      cell_addr <= base_next + col_next;
    end
  end

  assign frame_set = h_wrap && (vcount == V_LAST_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_frame <= 1'b0;
    end else begin
      irq_frame <= frame_set | (irq_frame & ~irq_clear);
    end
  end

`ifdef VGA_LINE_IRQ_EN
  logic [COORD_W-1:0] vcount_next;
  logic               line_set;

  // vcount_next never reaches V_TOTAL, so an out-of-range line_cmp cannot fire.
  always_comb begin
    vcount_next = v_wrap ? '0 : vcount + 1'b1;
    line_set    = h_wrap && (vcount_next == line_cmp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_line <= 1'b0;
    end else begin
      irq_line <= line_set | (irq_line & ~irq_clear);
    end
  end
`else
  logic unused_line_cmp;
  assign unused_line_cmp = ^line_cmp;
  assign irq_line        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen with a pixel-count raster model
module tb_vga_scan_gen;

  localparam int PD = 2;
  localparam int HA = 16, HSS = 18, HSE = 20, HT = 24;
  localparam int VA = 8,  VSS = 9,  VSE = 10, VT = 12;
  localparam int CW = 4,  CH = 4,   COLS = 4, AW = 12;
  localparam int FRAME  = HT * VT;
  localparam int BUDGET = 2 * FRAME * PD + 8;
`ifdef VGA_LINE_IRQ_EN
  localparam int LINE_EXP = 1;
`else
  localparam int LINE_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          irq_clear = 1'b0;
  logic [10:0]   line_cmp = 11'd12;
  logic          pix_en, hsync, vsync, blank, irq_frame, irq_line;
  logic [10:0]   hcount, vcount;
  logic [AW-1:0] cell_addr;
  logic [3:0]    glyph_x;
  logic [4:0]    glyph_y;

  int checks = 0;
  int errors = 0;

  vga_scan_gen #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CELL_W(CW), .CELL_H(CH), .COLS(COLS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .blank(blank),
    .hcount(hcount), .vcount(vcount), .cell_addr(cell_addr), .glyph_x(glyph_x),
    .glyph_y(glyph_y), .irq_frame(irq_frame), .irq_clear(irq_clear),
    .line_cmp(line_cmp), .irq_line(irq_line)
  );

  always #5 clk = ~clk;

  // Model: clocks since reset -> pixels stepped -> raster position; IRQs as set/clear events.
  int k = 0;
  int s = 0;
  bit m_step = 1'b0;
  bit m_irq_f = 1'b0;
  bit m_irq_l = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int p;
    bit set_f, set_l;
    if (!rst_n) begin
      k = 0; s = 0; m_step = 1'b0; m_irq_f = 1'b0; m_irq_l = 1'b0;
    end else begin
      k = k + 1;
      m_step = (PD == 1) || (k % PD == PD - 1);
      set_f = 1'b0;
      set_l = 1'b0;
      if (m_step) begin
        s = s + 1;
        p = s % FRAME;
        set_f = (p == VA * HT);
        set_l = (p == int'(line_cmp) * HT);
      end
      m_irq_f = set_f | (m_irq_f & !irq_clear);
`ifdef VGA_LINE_IRQ_EN
      m_irq_l = set_l | (m_irq_l & !irq_clear);
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int p, h, v;
    p = s % FRAME;
    h = p % HT;
    v = p / HT;
    check("pix_en", pix_en, m_step);
    check("hcount", hcount, h);
    check("vcount", vcount, v);
    check("hsync", hsync, (h >= HSS && h < HSE) ? 0 : 1);
    check("vsync", vsync, (v >= VSS && v < VSE) ? 0 : 1);
    check("blank", blank, (h >= HA || v >= VA) ? 1 : 0);
    check("cell_addr", cell_addr, (v / CH) * COLS + h / CW);
    check("glyph_x", glyph_x, h % CW);
    check("glyph_y", glyph_y, v % CH);
    check("irq_frame", irq_frame, m_irq_f);
    check("irq_line", irq_line, m_irq_l);
  end

  function automatic bit at_pix(input int h, input int v);
    return m_step && ((s % FRAME) % HT == h) && ((s % FRAME) / HT == v);
  endfunction

  task automatic goto_pix(input int h, input int v);
    int n = 0;
    while (!at_pix(h, v) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!at_pix(h, v)) begin
      errors++;
      $display("FAIL goto(%0d,%0d): not reached within %0d clocks", h, v, BUDGET);
    end
  endtask

  task automatic next_pix();
    int n = 0;
    @(negedge clk);
    while (!m_step && n < PD + 2) begin
      @(negedge clk);
      n++;
    end
    if (!m_step) begin
      errors++;
      $display("FAIL next_pix: no pixel enable within %0d clocks", PD + 2);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hcount", hcount, 0);
    check("rst_hsync", hsync, 1);
    check("rst_pix_en", pix_en, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("first_pix_h", hcount, 1);
    check("first_pix_en", pix_en, 1);

    goto_pix(15, 0); check("blank_h15", blank, 0);
    goto_pix(16, 0); check("blank_h16", blank, 1);
    goto_pix(17, 0); check("hsync_h17", hsync, 1);
    goto_pix(18, 0); check("hsync_h18", hsync, 0);
    goto_pix(19, 0); check("hsync_h19", hsync, 0);
    goto_pix(20, 0); check("hsync_h20", hsync, 1);
    goto_pix(23, 0); next_pix();
    check("hwrap_h", hcount, 0);
    check("hwrap_v", vcount, 1);

    goto_pix(5, 6);
    check("cell_5_6", cell_addr, 5);
    check("gx_5_6", glyph_x, 1);
    check("gy_5_6", glyph_y, 2);
    goto_pix(15, 7);
    check("cell_15_7", cell_addr, 7);
    check("gx_15_7", glyph_x, 3);
    check("gy_15_7", glyph_y, 3);

    goto_pix(23, 7);
    check("irq_before", irq_frame, 0);
    @(negedge clk);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    check("irq_set_wins", irq_frame, 1);
    check("line8_v", vcount, 8);
    check("line8_blank", blank, 1);
    check("line8_vsync", vsync, 1);
    repeat (4) @(negedge clk);
    check("irq_sticky", irq_frame, 1);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    check("irq_cleared", irq_frame, 0);

    goto_pix(0, 9);  check("vsync_l9", vsync, 0);
    goto_pix(0, 10); check("vsync_l10", vsync, 1);
    goto_pix(23, 11); next_pix();
    check("vwrap_h", hcount, 0);
    check("vwrap_v", vcount, 0);
    check("irq_no_reset", irq_frame, 0);

    line_cmp = 11'd3;
    goto_pix(23, 2);
    check("irq_line_pre", irq_line, 0);
    next_pix();
    check("irq_line_l3", irq_line, LINE_EXP);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    line_cmp = 11'd12;
    goto_pix(23, 11);
    goto_pix(10, 5);

    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_h", hcount, 0);
    check("mid_rst_v", vcount, 0);
    check("mid_rst_pix_en", pix_en, 0);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_irq", irq_frame, 0);
    check("mid_rst_cell", cell_addr, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_h", hcount, 1);
    check("post_rst_v", vcount, 0);
    check("post_rst_pix_en", pix_en, 1);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
